// File: rtl/line_detect_stream.sv
// line_detect_stream: streaming 3x3 line-detection convolver with two line buffers,
// per-pixel kernel direction and a 3-stage saturating output pipeline.
module line_detect_stream #(
  parameter int DW    = 8,
  parameter int IMG_W = 64,
  parameter int CW    = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_pix,
  input  logic [1:0]    mode,
  output logic          out_valid,
  output logic [DW-1:0] out_pix,
  output logic [CW-1:0] out_col
);
  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] p [9];
  logic [CW-1:0] col, c, col0, col1;
  logic [1:0]    row, r, mode0;
  logic          v0, v1, wrap;
  logic [DW+1:0] sl_c, sl;
  logic [DW+3:0] tot;
  logic [DW+2:0] so;
  logic signed [DW+3:0] y;
  assign c    = in_sof ? '0 : col;
  assign r    = in_sof ? '0 : row;
  assign wrap = c == CW'(IMG_W - 1);
  // lb0 holds the previous row, lb1 the row before that; contents need no reset
  always_ff @(posedge clk)
    if (in_valid) begin
      lb1[c] <= lb0[c];
      lb0[c] <= in_pix;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col   <= '0;
      row   <= '0;
      v0    <= 1'b0;
      col0  <= '0;
      mode0 <= '0;
      for (int i = 0; i < 9; i++) p[i] <= '0;
    end else begin
      v0    <= in_valid && r == 2'd2 && c >= CW'(2);
      col0  <= c - CW'(1);
      mode0 <= mode;
      if (in_valid) begin
        col  <= wrap ? '0 : c + CW'(1);
        row  <= wrap && r != 2'd2 ? r + 2'd1 : r;
        p[0] <= p[1];
        p[1] <= p[2];
        p[2] <= lb1[c];
        p[3] <= p[4];
        p[4] <= p[5];
        p[5] <= lb0[c];
        p[6] <= p[7];
        p[7] <= p[8];
        p[8] <= in_pix;
      end
    end
  // S_other is derived as the full 3x3 sum minus the centre line
  always_comb begin
    tot = '0;
    for (int i = 0; i < 9; i++) tot = tot + (DW+4)'(p[i]);
    sl_c = (DW+2)'(p[4])
         + (DW+2)'(mode0 == 2'd0 ? p[3] : mode0 == 2'd1 ? p[1] : mode0 == 2'd2 ? p[0] : p[2])
         + (DW+2)'(mode0 == 2'd0 ? p[5] : mode0 == 2'd1 ? p[7] : mode0 == 2'd2 ? p[8] : p[6]);
  end
  assign y = $signed({1'b0, sl, 1'b0}) - $signed({1'b0, so});
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1        <= 1'b0;
      col1      <= '0;
      sl        <= '0;
      so        <= '0;
      out_valid <= 1'b0;
      out_col   <= '0;
      out_pix   <= '0;
    end else begin
      v1        <= v0;
      col1      <= col0;
      sl        <= sl_c;
      so        <= (DW+3)'(tot - (DW+4)'(sl_c));
      out_valid <= v1;
      out_col   <= col1;
      out_pix   <= y[DW+3] ? '0 : |y[DW+2:DW] ? '1 : y[DW-1:0];
    end
endmodule

// File: tb/tb_line_detect_stream.sv
// tb_line_detect_stream: scoreboard bench driving an 8-bit and a 10-bit instance in parallel.
module tb_line_detect_stream;
  localparam int W = 8;
  logic clk = 0, rst = 1, in_valid = 0, in_sof = 0;
  logic [9:0] in_pix = '0;
  logic [1:0] mode = '0;
  logic ov8, ov10;
  logic [7:0] op8;
  logic [9:0] op10;
  logic [2:0] oc8, oc10;
  typedef struct {int col; int pix; int edge_n;} exp_t;
  exp_t q8[$], q10[$];
  exp_t e8, e10;
  int checks = 0, failures = 0, n8 = 0, n10 = 0, cyc = 0;
  int img[16][W];
  int mr = 0, mc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_detect_stream #(.DW(8), .IMG_W(W)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix[7:0]),
    .mode(mode), .out_valid(ov8), .out_pix(op8), .out_col(oc8));
  line_detect_stream #(.DW(10), .IMG_W(W)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pix(in_pix),
    .mode(mode), .out_valid(ov10), .out_pix(op10), .out_col(oc10));

  function automatic int conv(int r, int c, int m, int mx);
    int p[9];
    int a, b, line, tot, y;
    tot = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        p[i*3+j] = img[r-2+i][c-2+j] & mx;
        tot += p[i*3+j];
      end
    case (m)
      0: begin a = p[3]; b = p[5]; end
      1: begin a = p[1]; b = p[7]; end
      2: begin a = p[0]; b = p[8]; end
      default: begin a = p[2]; b = p[6]; end
    endcase
    line = a + p[4] + b;
    y = 2 * line - (tot - line);
    return y < 0 ? 0 : y > mx ? mx : y;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0;
      in_sof = 0;
    end
  endtask

  task automatic send(input int pix, input int m, input bit sof, input int gap);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 0;
      in_pix = 10'($urandom);
      mode = 2'($urandom);
      in_sof = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1;
    in_pix = 10'(pix);
    mode = 2'(m);
    in_sof = sof;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = pix;
    if (mr >= 2 && mc >= 2) begin
      q8.push_back('{mc - 1, conv(mr, mc, m, 255), cyc + 3});
      q10.push_back('{mc - 1, conv(mr, mc, m, 1023), cyc + 3});
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      if (mr < 15) mr++;
    end
  endtask

  // kind: 0 flat 100, 1 row1=255, 2 diagonal 10s, 3 pattern, 4 row1=1023, 5 lone 1023; m=4 cycles modes
  task automatic frame(input int rows, input int kind, input int m, input bit sof, input int gapmax);
    int pix;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < W; c++) begin
        case (kind)
          0: pix = 100;
          1: pix = r == 1 ? 255 : 0;
          2: pix = (r == c && r < 3) ? 10 : 0;
          3: pix = (r * 53 + c * 29 + 7) % 256;
          4: pix = r == 1 ? 1023 : 0;
          default: pix = (r == 0 && c == 0) ? 1023 : 0;
        endcase
        send(pix, m < 4 ? m : (r + c) % 4, sof && r == 0 && c == 0,
             gapmax > 0 ? $urandom_range(0, gapmax) : 0);
      end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (ov8) begin
      n8++;
      checks++;
      if (q8.size() == 0) begin
        failures++;
        $display("FAIL out8 unexpected col=%0d pix=%0d edge=%0d", oc8, op8, cyc);
      end else begin
        e8 = q8.pop_front();
        if (int'(oc8) != e8.col || int'(op8) != e8.pix || cyc != e8.edge_n) begin
          failures++;
          $display("FAIL out8 got col=%0d pix=%0d edge=%0d expected col=%0d pix=%0d edge=%0d",
                   oc8, op8, cyc, e8.col, e8.pix, e8.edge_n);
        end
      end
    end
    if (ov10) begin
      n10++;
      checks++;
      if (q10.size() == 0) begin
        failures++;
        $display("FAIL out10 unexpected col=%0d pix=%0d edge=%0d", oc10, op10, cyc);
      end else begin
        e10 = q10.pop_front();
        if (int'(oc10) != e10.col || int'(op10) != e10.pix || cyc != e10.edge_n) begin
          failures++;
          $display("FAIL out10 got col=%0d pix=%0d edge=%0d expected col=%0d pix=%0d edge=%0d",
                   oc10, op10, cyc, e10.col, e10.pix, e10.edge_n);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int b8, b10;
    repeat (3) @(negedge clk);
    chk("reset_valid8", int'(ov8), 0);
    chk("reset_pix8", int'(op8), 0);
    chk("reset_col8", int'(oc8), 0);
    chk("reset_valid10", int'(ov10), 0);
    chk("reset_pix10", int'(op10), 0);
    chk("reset_col10", int'(oc10), 0);
    rst = 0;
    for (int m = 0; m < 4; m++) begin
      b8 = n8;
      b10 = n10;
      frame(4, 0, m, 1, 0);
      idle(5);
      chk("flat_count8", n8 - b8, 12);
      chk("flat_count10", n10 - b10, 12);
    end
    frame(4, 1, 0, 1, 0);
    idle(5);
    frame(3, 2, 2, 1, 0);
    frame(3, 2, 3, 1, 0);
    frame(3, 2, 0, 1, 0);
    frame(3, 2, 4, 1, 0);
    idle(5);
    frame(5, 3, 4, 1, 0);
    idle(5);
    b8 = n8;
    frame(5, 3, 4, 1, 3);
    idle(5);
    chk("gap_count8", n8 - b8, 18);
    for (int k = 0; k < 12; k++) send((k * 17) % 256, 1, k == 0, 0);
    @(negedge clk);
    in_valid = 0;
    #2 rst = 1;
    mr = 0;
    mc = 0;
    #1;
    chk("midreset_valid8", int'(ov8), 0);
    chk("midreset_col10", int'(oc10), 0);
    @(negedge clk);
    rst = 0;
    b10 = n10;
    frame(4, 3, 1, 0, 0);
    idle(5);
    chk("postreset_count10", n10 - b10, 12);
    frame(3, 4, 0, 1, 0);
    frame(3, 5, 0, 1, 0);
    idle(6);
    chk("q8_drained", q8.size(), 0);
    chk("q10_drained", q10.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
